// File: rtl/moore_seq_1100_nov.sv
// Moore FSM that flags each non-overlapping "1100" on the serial input in_seq.
// det_out is decoded from the registered state only, so it never follows in_seq combinationally.
module moore_seq_1100_nov (
  input  logic in_seq,
  input  logic clk,
  input  logic rst,
  output logic det_out
);

  localparam logic [2:0] S0 = 3'd0;
  localparam logic [2:0] S1 = 3'd1;
  localparam logic [2:0] S2 = 3'd2;
  localparam logic [2:0] S3 = 3'd3;
  localparam logic [2:0] S4 = 3'd4;

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       bit_one;

  // An X/Z sample compares as unknown, which the if-tests below treat as a 0.
  assign bit_one = (in_seq == 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S0;
    case (state_q)
      S0: if (bit_one) state_d = S1; else state_d = S0;
      S1: if (bit_one) state_d = S2; else state_d = S0;
      S2: if (bit_one) state_d = S2; else state_d = S3;
      S3: if (bit_one) state_d = S1; else state_d = S4;
      // After a detection matching restarts from scratch.
      S4: if (bit_one) state_d = S1; else state_d = S0;
      default: state_d = S0;
    endcase
  end

  always_comb begin
    det_out = 1'b0;
    case (state_q)
      S4:      det_out = 1'b1;
      default: det_out = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_moore_seq_1100_nov.sv
// Self-checking bench for moore_seq_1100_nov: directed sequences, forced illegal states,
// asynchronous reset and a random stream, all against a bit-history reference model.
module tb_moore_seq_1100_nov;

  logic in_seq;
  logic clk;
  logic rst;
  logic det_out;

  int checks;
  int errors;

  // Reference model: the last four bits seen since reset or the previous detection.
  logic [3:0] hist;
  int         since_restart;
  logic       exp_det;

  moore_seq_1100_nov dut (
    .in_seq (in_seq),
    .clk    (clk),
    .rst    (rst),
    .det_out(det_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [2:0] observed, input logic [2:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    hist          = 4'b0000;
    since_restart = 0;
    exp_det       = 1'b0;
  endtask

  // Drive one bit at the falling edge, let the rising edge sample it, then compare.
  task automatic applyStimulus(input logic b, input string tag);
    @(negedge clk);
    in_seq = b;
    @(posedge clk);
    #1;
    hist = {hist[2:0], b};
    since_restart++;
    exp_det = (since_restart >= 4) && (hist == 4'b1100);
    if (exp_det) since_restart = 0;
    checkOutput(tag, {2'b00, det_out}, {2'b00, exp_det});
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("reset_det", {2'b00, det_out}, 3'd0);
    checkOutput("reset_state", dut.state_q, 3'd0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic applySeq(input logic [15:0] bits, input int len, input string tag);
    for (int i = len - 1; i >= 0; i--) applyStimulus(bits[i], tag);
  endtask

  initial begin
    logic [15:0] seq_v;
    int          pulses;
    checks = 0;
    errors = 0;
    in_seq = 1'b0;
    rst    = 1'b0;
    modelReset();

    doReset();

    // Two back-to-back detections of 1100.
    seq_v  = 16'b1100_1100;
    pulses = 0;
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(seq_v[i], "seq_11001100");
      if (det_out === 1'b1) pulses++;
    end
    checkOutput("seq_11001100_pulses", pulses[2:0], 3'd2);

    // Extra leading ones stay in the "11" match.
    doReset();
    seq_v = 16'b11_1100;
    applySeq(seq_v, 6, "seq_111100");
    checkOutput("seq_111100_last", {2'b00, det_out}, 3'd1);

    // Mismatch at "1101" returns to the one-bit prefix.
    doReset();
    seq_v  = 16'b101_0110_1100;
    pulses = 0;
    for (int i = 10; i >= 0; i--) begin
      applyStimulus(seq_v[i], "seq_10101101100");
      if (det_out === 1'b1) pulses++;
    end
    checkOutput("seq_10101101100_pulses", pulses[2:0], 3'd1);
    checkOutput("seq_10101101100_last", {2'b00, det_out}, 3'd1);

    // Reset between edges after "110" discards the partial match.
    doReset();
    seq_v = 16'b110;
    applySeq(seq_v, 3, "pre_midreset");
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midreset_state", dut.state_q, 3'd0);
    checkOutput("midreset_det", {2'b00, det_out}, 3'd0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, "after_midreset");

    // Reset while the detection pulse is high clears it at once.
    doReset();
    seq_v = 16'b1100;
    applySeq(seq_v, 4, "pre_s4reset");
    #2;
    rst = 1'b1;
    #1;
    checkOutput("s4reset_det", {2'b00, det_out}, 3'd0);
    checkOutput("s4reset_state", dut.state_q, 3'd0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;

    // Unused state codes decode to no detection and recover to idle.
    for (int code = 5; code <= 7; code++) begin
      @(negedge clk);
      in_seq = 1'b0;
      force dut.state_q = code[2:0];
      #1;
      checkOutput("illegal_det", {2'b00, det_out}, 3'd0);
      release dut.state_q;
      @(posedge clk);
      #1;
      checkOutput("illegal_recover", dut.state_q, 3'd0);
    end
    doReset();

    for (int i = 0; i < 20; i++) applyStimulus(1'b0, "const_zero");
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, "const_one");

    doReset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        doReset();
      end else begin
        applyStimulus(1'($urandom_range(0, 1)), "random");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
